// File: rtl/pipelined_csa_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready flow control.
// Stage gi resolves block gi: both carry hypotheses are summed and the
// carry registered by the previous stage (or the live carry-in for stage 0)
// picks one. Results leave straight from the last stage's registers.
module pipelined_csa_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NUM_BLK = WIDTH / BLOCK;

    generate
        if (WIDTH < 1 || BLOCK < 1 || BLOCK > WIDTH || (WIDTH % BLOCK) != 0) begin : g_bad_params
            $error("pipelined_csa_adder: illegal WIDTH/BLOCK combination");
        end
    endgenerate

    // Whole pipeline advances together; a stalled output freezes every stage.
    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Subtraction is a + ~b + 1, with the borrow-in folded into the carry.
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    assign b_eff = b ^ {WIDTH{sub}};
    assign c0    = cin ^ sub;

    // Per-stage state; stage gi has resolved blocks 0..gi.
    logic             valid_reg [NUM_BLK];
    logic [WIDTH-1:0] sum_reg   [NUM_BLK];
    logic [WIDTH-1:0] a_reg     [NUM_BLK];
    logic [WIDTH-1:0] b_reg     [NUM_BLK];
    logic             carry_reg [NUM_BLK];
    logic             ovf_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BLK; gi++) begin : g_stage
            logic             v_src;
            logic [WIDTH-1:0] a_src;
            logic [WIDTH-1:0] b_src;
            logic [WIDTH-1:0] s_src;
            logic             c_src;
            logic [BLOCK:0]   s0;
            logic [BLOCK:0]   s1;
            logic [BLOCK:0]   sel;
            logic [WIDTH-1:0] s_next;

            if (gi == 0) begin : g_src
                assign v_src = in_valid;
                assign a_src = a;
                assign b_src = b_eff;
                assign s_src = '0;
                assign c_src = c0;
            end else begin : g_src
                assign v_src = valid_reg[gi-1];
                assign a_src = a_reg[gi-1];
                assign b_src = b_reg[gi-1];
                assign s_src = sum_reg[gi-1];
                assign c_src = carry_reg[gi-1];
            end

            // Both carry-in hypotheses for this block, then select.
            always_comb begin
                s0     = {1'b0, a_src[gi*BLOCK +: BLOCK]} + {1'b0, b_src[gi*BLOCK +: BLOCK]};
                s1     = s0 + {{BLOCK{1'b0}}, 1'b1};
                sel    = c_src ? s1 : s0;
                s_next = s_src;
                s_next[gi*BLOCK +: BLOCK] = sel[BLOCK-1:0];
            end

            // Stage register: clears on reset, holds while the output stalls.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                    sum_reg[gi]   <= '0;
                    a_reg[gi]     <= '0;
                    b_reg[gi]     <= '0;
                    carry_reg[gi] <= 1'b0;
                end else if (adv) begin
                    valid_reg[gi] <= v_src;
                    sum_reg[gi]   <= s_next;
                    a_reg[gi]     <= a_src;
                    b_reg[gi]     <= b_src;
                    carry_reg[gi] <= sel[BLOCK];
                end
            end

            if (gi == NUM_BLK - 1) begin : g_ovf
                // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        ovf_reg <= 1'b0;
                    end else if (adv) begin
                        ovf_reg <= sel[BLOCK] ^ (sel[BLOCK-1] ^ a_src[WIDTH-1] ^ b_src[WIDTH-1]);
                    end
                end
            end
        end
    endgenerate

    assign out_valid = valid_reg[NUM_BLK-1];
    assign sum       = sum_reg[NUM_BLK-1];
    assign cout      = carry_reg[NUM_BLK-1];
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_pipelined_csa_adder.sv
// Directed bench for pipelined_csa_adder at WIDTH=16, BLOCK=4 (latency 4).
// Inputs are driven and outputs sampled on the falling edge.
module tb_pipelined_csa_adder;
    localparam int WIDTH = 16;
    localparam int LAT   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    pipelined_csa_adder #(.WIDTH(WIDTH), .BLOCK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vcin;
        logic        vsub;
        logic [15:0] esum;
        logic        ecout;
        logic        eovf;
    } vec_t;

    vec_t vecs [9];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // One isolated operation: accept, wait for the result, compare all fields.
    task automatic run_one(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; a = v.va; b = v.vb; cin = v.vcin; sub = v.vsub; out_ready = 1'b1;
        #1;
        check($sformatf("v%0d_in_ready", idx), {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("v%0d_latency", idx), lat, LAT);
        check($sformatf("v%0d_sum", idx), {16'd0, sum}, {16'd0, v.esum});
        check($sformatf("v%0d_cout", idx), {31'd0, cout}, {31'd0, v.ecout});
        check($sformatf("v%0d_ovf", idx), {31'd0, ovf}, {31'd0, v.eovf});
        $display("op %0d: a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
                 idx, v.va, v.vb, v.vcin, v.vsub, sum, cout, ovf, lat);
    endtask

    initial begin
        int   sent, recv, cyc, stall_cnt, seen;
        logic stalled;
        logic [15:0] held;

        //          a        b        cin   sub   sum      cout  ovf
        vecs[0] = '{16'd999, 16'd0,   1'b1, 1'b0, 16'd1000, 1'b0, 1'b0};
        vecs[1] = '{16'd14,  16'd1,   1'b1, 1'b0, 16'd16,   1'b0, 1'b0};
        vecs[2] = '{16'hFFFF,16'h0000,1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h7FFF,16'h0001,1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'd5,   16'd7,   1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[5] = '{16'h8000,16'h0001,1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{16'd10,  16'd3,   1'b1, 1'b1, 16'd6,    1'b1, 1'b0};
        vecs[7] = '{16'h1234,16'h4321,1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[8] = '{16'h8000,16'h8000,1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        // Reset held two cycles with a live operand that must never emerge.
        rst = 1'b1; in_valid = 1'b1; a = 16'd5; b = 16'd0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_sum", {16'd0, sum}, 32'd0);
            check("rst_cout", {31'd0, cout}, 32'd0);
            check("rst_ovf", {31'd0, ovf}, 32'd0);
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_no_emit", seen, 0);
        $display("reset: out_valid count after release=%0d", seen);

        for (int i = 0; i < 9; i++) run_one(vecs[i], i);

        // Back-to-back stream with the consumer stalled in cycles 5..7.
        sent = 0; recv = 0; cyc = 0; stall_cnt = 0; stalled = 1'b0; held = '0;
        while (recv < 6 && cyc < 40) begin
            @(negedge clk);
            out_ready = !(cyc >= 5 && cyc <= 7);
            in_valid  = (sent < 6);
            a = 16'(sent); b = 16'd100; cin = 1'b0; sub = 1'b0;
            #1;
            check("bp_in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
            if (stalled) begin
                check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
                check("bp_hold_sum", {16'd0, sum}, {16'd0, held});
            end
            if (out_valid && out_ready) begin
                check("bp_order", {16'd0, sum}, 32'd100 + 32'(recv));
                $display("stream out %0d: sum=%0d cycle=%0d", recv, sum, cyc);
                recv++;
            end
            stalled = out_valid && !out_ready;
            if (stalled) stall_cnt++;
            held = sum;
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_count", recv, 6);
        check("bp_stall_cycles", stall_cnt, 3);
        // Nothing extra may follow the six results.
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("bp_no_dup", seen, 0);

        // Reset while three operations are in flight.
        @(negedge clk); in_valid = 1'b1; a = 16'd1; b = 16'd0;
        @(negedge clk); a = 16'd2;
        @(negedge clk); a = 16'd3; rst = 1'b1;
        @(negedge clk); rst = 1'b0; in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (out_valid) seen++;
            @(negedge clk);
        end
        check("midrst_no_emit", seen, 0);
        $display("mid-flight reset: out_valid count afterwards=%0d", seen);
        run_one(vecs[7], 9);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/pipelined_csa_adder.md
# pipelined_csa_adder

Parametrised, pipelined carry-select adder/subtractor with valid/ready handshakes on both sides. The operand is split into `WIDTH/BLOCK` blocks. Each pipeline stage resolves one block by computing both carry-in hypotheses and selecting with the registered carry from the previous stage. It replaces the fixed 16-bit combinational carry-select adder in the arithmetic library wherever `WIDTH` or clock frequency exceeds what a single-cycle adder can close. It sits between any streaming producer and consumer of operand pairs.

## Interface
- `WIDTH`, 16, operand and sum width in bits; must be ≥ 1.
- `BLOCK`, 4, carry-select block width. Must satisfy 1 ≤ `BLOCK` ≤ `WIDTH` and `WIDTH % BLOCK == 0`; otherwise elaboration fails.
- Derived: `NUM_BLK = WIDTH/BLOCK`, which is both the pipeline depth and the latency.
- One clock; reset is synchronous and active-high.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand pair present.
- `in_ready` out 1: block can accept this cycle.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `cin` in 1: carry-in in add mode; borrow-in in sub mode.
- `sub` in 1: 0 = add, 1 = subtract.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer accepts this cycle.
- `sum` out WIDTH: result.
- `cout` out 1: raw carry out of the MSB. In sub mode, 1 means no borrow.
- `ovf` out 1: signed overflow, computed as carry into MSB XOR carry out of MSB.

## Operation
- Effective operands:
  - `b_eff = b ^ {WIDTH{sub}}`
  - `c0 = cin ^ sub`
  - Add mode: `sum = a + b + cin`.
  - Sub mode: `sum = a - b - cin` (mod 2^WIDTH).
- Stage k (1..NUM_BLK) holds:
  - a valid bit;
  - sum bits of blocks 0..k-1;
  - the carry into block k;
  - carry into the MSB, once the MSB block is resolved;
  - delayed a/b_eff bits for blocks k..NUM_BLK-1 (unresolved bits only).
- Per-stage computation:
  - Stage 1 computes block 0 from the live inputs and `c0`.
  - Stage k+1 computes block k as two BLOCK-bit sums (carry-in 0 and 1), then muxes by the stage-k carry register.
- Outputs `sum`/`cout`/`ovf`/`out_valid` come directly from the stage-NUM_BLK registers. No combinational path exists from `a`/`b` to outputs.
- Flow control is a global enable: `adv = ~out_valid | out_ready`, and `in_ready = adv`.
  - When `adv=1`, every stage shifts forward by one.
  - Stage 1 valid is loaded from `in_valid`; bubbles (valid=0) propagate normally.
  - When `adv=0`, all stage registers hold, including data.
- Ordering: results emerge strictly in acceptance order. No drop, no duplication.
- `BLOCK = WIDTH` degenerates to one stage with latency 1. `BLOCK = 1` gives a ripple pipeline of WIDTH stages.

## Timing
- Reset (`rst=1` at an edge):
  - all stage valid bits, `out_valid`, `sum`, `cout` and `ovf` go to 0 after that edge;
  - `in_ready` reads 1 in the following cycle.
- In-flight operands at reset are discarded and never emitted.
- `in_valid` asserted during a reset cycle is not accepted.
- Acceptance: `in_valid & in_ready` high in cycle 0 gives `out_valid=1` with the result in cycle NUM_BLK, provided `adv=1` throughout.
- Throughput: one result per cycle when `out_ready` is held high.
- Output hold: while `out_valid=1 & out_ready=0`, `sum`/`cout`/`ovf` are stable and `in_ready=0`.
- `in_ready` is combinational from `out_ready` and the `out_valid` register only. It never depends on `in_valid`.
- Simultaneous output handshake and new input in the same cycle: both complete, and the pipeline shifts once.

## Test plan
Default parameters (`WIDTH=16`, `BLOCK=4`, latency 4).
- Reset: hold `rst` 2 cycles with `in_valid=1`, a=5 → `out_valid=0`, `sum=0`, `cout=0`, `ovf=0` throughout. After release, `in_ready=1` and no result ever appears for a=5.
- Latency/basic: accept a=999, b=0, cin=1, sub=0 in cycle 0 → `out_valid` first high in cycle 4 with sum=1000, cout=0, ovf=0. Also a=14, b=1, cin=1 → sum=16.
- Full-width carry: a=0xFFFF, b=0, cin=1 → sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=1, cin=0 → sum=0x8000, cout=0, ovf=1.
- Subtract: a=5, b=7, sub=1, cin=0 → sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=1, sub=1, cin=0 → sum=0x7FFF, cout=1, ovf=1. Then a=10, b=3, sub=1, cin=1 → sum=6, cout=1.
- Backpressure: stream 6 back-to-back ops (a=i, b=100, i=0..5) with `out_ready=0` during cycles 5–7 → `in_ready=0` exactly while `out_valid & ~out_ready`. Outputs are 100..105 in order, each exactly once, with values stable during the stall.
- Reset mid-flight: accept 3 ops, assert `rst` for one cycle in cycle 2 → `out_valid=0` from cycle 3 onward. None of the 3 results is emitted, and the next op accepted after reset returns correctly 4 cycles later.
